// File: rtl/paddle_pot_emulator_pkg.sv
// Shared constants and helpers for the paddle potentiometer emulator.
// Defaults model the AY-3-8500 RC paddle network; LEFT/RIGHT index the two channels.
package paddle_pot_emulator_pkg;

    localparam int POS_W     = 8;
    localparam int PMAX      = 200;
    localparam int PCENTRE   = 100;
    localparam int OFFSET    = 16;
    localparam int STEP      = 2;
    localparam int FAST_STEP = 4;
    localparam int HOLD      = 8;
    localparam int CNT_W     = 9;
    localparam int HOLD_W    = 4;

    localparam int LEFT  = 0;
    localparam int RIGHT = 1;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DN
    } move_t;

    // Both or neither pressed means no movement and a cleared hold count.
    function automatic move_t decode_move(input logic up, input logic dn);
        if (up && !dn) return MOVE_UP;
        if (dn && !up) return MOVE_DN;
        return MOVE_NONE;
    endfunction

endpackage

// File: rtl/paddle_pot_emulator_pot_channel.sv
// One paddle channel: charge counter, registered threshold (pot_in 1 clk after count hits it),
// dwn fall edge detect and per-frame position/hold update. No backpressure; free-running.
module pot_channel
    import paddle_pot_emulator_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             game_reset,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             dwn,
    output logic             pot_in,
    output logic [POS_W-1:0] pos
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_L   = HOLD_W'(HOLD);
    localparam logic [POS_W:0]    PMAX_L   = (POS_W+1)'(PMAX);
    localparam logic [POS_W-1:0]  CENTRE_L = POS_W'(PCENTRE);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  thr;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic [POS_W-1:0]  pos_nxt;
    logic [POS_W:0]    step_amt;
    logic [POS_W:0]    diff;
    logic [POS_W:0]    sum;
    logic              dwn_q;
    logic              frame;
    move_t             move;

    assign frame = dwn_q && !dwn;
    assign thr   = CNT_W'(pos) + CNT_W'(OFFSET);

    // The step size follows the hold count as it will be after this frame.
    always_comb begin
        move     = decode_move(btn_up, btn_dn);
        hold_nxt = '0;
        if (move != MOVE_NONE)
            hold_nxt = (hold >= HOLD_L) ? HOLD_L : hold + 1'b1;
        step_amt = (hold_nxt >= HOLD_L) ? (POS_W+1)'(FAST_STEP) : (POS_W+1)'(STEP);
        diff     = {1'b0, pos} - step_amt;
        sum      = {1'b0, pos} + step_amt;
        pos_nxt  = pos;
        case (move)
            MOVE_UP: pos_nxt = diff[POS_W] ? '0 : diff[POS_W-1:0];
            MOVE_DN: pos_nxt = (sum > PMAX_L) ? PMAX_L[POS_W-1:0] : sum[POS_W-1:0];
            default: pos_nxt = pos;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            pot_in <= 1'b0;
            dwn_q  <= 1'b1;
        end else begin
            dwn_q  <= dwn;
            pot_in <= !dwn && (cnt >= thr);
            if (dwn)
                cnt <= '0;
            else if (ce && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos  <= CENTRE_L;
            hold <= '0;
        end else if (game_reset) begin
            pos  <= CENTRE_L;
            hold <= '0;
        end else if (frame) begin
            pos  <= pos_nxt;
            hold <= hold_nxt;
        end
    end

endmodule

// File: rtl/paddle_pot_emulator.sv
// Two independent paddle pot channels feeding the AY-3-8500 lpIN/rpIN inputs.
// pot_in registered 1 clk after threshold; no backpressure, channels share no state.
module paddle_pot_emulator
    import paddle_pot_emulator_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               game_reset,
    input  logic [1:0]         btn_up,
    input  logic [1:0]         btn_dn,
    input  logic [1:0]         dwn,
    output logic [1:0]         pot_in,
    output logic [2*POS_W-1:0] pos
);

    pot_channel u_left (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .game_reset (game_reset),
        .btn_up     (btn_up[LEFT]),
        .btn_dn     (btn_dn[LEFT]),
        .dwn        (dwn[LEFT]),
        .pot_in     (pot_in[LEFT]),
        .pos        (pos[LEFT*POS_W +: POS_W])
    );

    pot_channel u_right (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .game_reset (game_reset),
        .btn_up     (btn_up[RIGHT]),
        .btn_dn     (btn_dn[RIGHT]),
        .dwn        (dwn[RIGHT]),
        .pot_in     (pot_in[RIGHT]),
        .pos        (pos[RIGHT*POS_W +: POS_W])
    );

endmodule

// File: tb/tb_paddle_pot_emulator.sv
// Bench for paddle_pot_emulator: directed scenarios plus randomized traffic, all
// checked every cycle against a frame/tick level reference model.
module tb_paddle_pot_emulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        game_reset;
    logic [1:0]  btn_up;
    logic [1:0]  btn_dn;
    logic [1:0]  dwn;
    logic [1:0]  pot_in;
    logic [15:0] pos;

    int checks = 0;
    int errors = 0;

    // Reference state: ticks seen since discharge ended, paddle position, frames held.
    int m_ticks[2];
    int m_pos[2];
    int m_hold[2];
    bit m_dwn_prev[2];
    bit m_pin[2];

    always #5 clk = ~clk;

    paddle_pot_emulator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .game_reset (game_reset),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .dwn        (dwn),
        .pot_in     (pot_in),
        .pos        (pos)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_ticks[ch]    = 0;
            m_pos[ch]      = 100;
            m_hold[ch]     = 0;
            m_dwn_prev[ch] = 1'b1;
            m_pin[ch]      = 1'b0;
        end
    endtask

    // One clock of the reference, using the inputs present at that edge.
    task automatic model_edge();
        for (int ch = 0; ch < 2; ch++) begin
            bit up = btn_up[ch];
            bit dn = btn_dn[ch];
            bit d  = dwn[ch];
            int s;
            m_pin[ch] = !d && (m_ticks[ch] >= m_pos[ch] + 16);
            if (d)
                m_ticks[ch] = 0;
            else if (ce)
                m_ticks[ch] = (m_ticks[ch] + 1 > 511) ? 511 : m_ticks[ch] + 1;
            if (game_reset) begin
                m_pos[ch]  = 100;
                m_hold[ch] = 0;
            end else if (m_dwn_prev[ch] && !d) begin
                if (up != dn) m_hold[ch] = (m_hold[ch] + 1 > 8) ? 8 : m_hold[ch] + 1;
                else          m_hold[ch] = 0;
                s = (m_hold[ch] >= 8) ? 4 : 2;
                if (up && !dn) m_pos[ch] = (m_pos[ch] - s < 0) ? 0 : m_pos[ch] - s;
                if (dn && !up) m_pos[ch] = (m_pos[ch] + s > 200) ? 200 : m_pos[ch] + s;
            end
            m_dwn_prev[ch] = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("pot_in_l", pot_in[0], m_pin[0]);
        check("pot_in_r", pot_in[1], m_pin[1]);
        check("pos_l", pos[7:0], m_pos[0]);
        check("pos_r", pos[15:8], m_pos[1]);
    endtask

    task automatic frame(input int ch, input int gap);
        dwn[ch] = 1'b1;
        step();
        step();
        dwn[ch] = 1'b0;
        repeat (gap) step();
    endtask

    // Clocks from the dwn fall until pot_in rises; 700 means it never rose.
    task automatic measure(input int ch, output int n);
        dwn[ch] = 1'b1;
        step();
        step();
        dwn[ch] = 1'b0;
        n = 0;
        while (pot_in[ch] !== 1'b1 && n < 700) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int guard;
        int exp2[10] = '{98, 96, 94, 92, 90, 88, 86, 82, 78, 74};

        reset_n    = 1'b0;
        ce         = 1'b0;
        game_reset = 1'b0;
        btn_up     = 2'b00;
        btn_dn     = 2'b00;
        dwn        = 2'b11;
        model_reset();
        #12;
        check("rst_pot_in", pot_in, 0);
        check("rst_pos", pos, {8'd100, 8'd100});
        @(negedge clk);
        reset_n = 1'b1;
        ce      = 1'b1;
        step();

        // Centred paddle: threshold 116 ticks, visible 117 clocks after dwn falls.
        measure(0, n);
        check("t1_latency", n, 117);
        check("t1_pos", pos[7:0], 100);

        btn_up[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame(0, 3);
            check("t2_pos_seq", pos[7:0], exp2[i]);
        end
        btn_up[0] = 1'b0;

        btn_dn[1] = 1'b1;
        repeat (60) frame(1, 2);
        check("t3_pos_max", pos[15:8], 200);
        measure(1, n);
        check("t3_latency_max", n, 217);
        btn_dn[1] = 1'b0;
        btn_up[1] = 1'b1;
        repeat (60) frame(1, 2);
        check("t3_pos_min", pos[15:8], 0);
        measure(1, n);
        check("t3_latency_min", n, 17);
        btn_up[1] = 1'b0;

        btn_up[0] = 1'b1;
        btn_dn[0] = 1'b1;
        repeat (5) frame(0, 2);
        check("t4_both_pos", pos[7:0], 74);
        btn_dn[0] = 1'b0;
        frame(0, 2);
        check("t4_first_step", pos[7:0], 72);
        btn_up[0] = 1'b0;

        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        check("t5_recentre", pos[7:0], 100);
        dwn[0] = 1'b1;
        step();
        step();
        dwn[0] = 1'b0;
        repeat (50) step();
        dwn[0] = 1'b1;
        step();
        check("t5_abort_pot_in", pot_in[0], 0);
        measure(0, n);
        check("t5_restart_latency", n, 117);
        repeat (600) step();
        check("t5_saturated_pot_in", pot_in[0], 1);

        guard = 0;
        while (m_pos[0] > 40 && guard < 100) begin
            btn_up[0] = 1'b1;
            frame(0, 2);
            btn_up[0] = 1'b0;
            frame(0, 2);
            guard++;
        end
        check("t6_pos_40", pos[7:0], 40);
        btn_up[0] = 1'b1;
        dwn[0]    = 1'b1;
        step();
        step();
        dwn[0]     = 1'b0;
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        btn_up[0]  = 1'b0;
        check("t6_greset_vs_frame", pos[7:0], 100);

        repeat (130) step();
        check("t6_pre_reset_pot_in", pot_in[0], 1);
        btn_dn[1] = 1'b1;
        frame(1, 2);
        btn_dn[1] = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("t6_async_pot_in", pot_in, 0);
        check("t6_async_pos", pos, {8'd100, 8'd100});
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 20000; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 149) == 0) dwn[ch] = ~dwn[ch];
            end
            if ($urandom_range(0, 39) == 0) begin
                btn_up = 2'($urandom_range(0, 3));
                btn_dn = 2'($urandom_range(0, 3));
            end
            game_reset = ($urandom_range(0, 799) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
